// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle RV32M multiply/divide unit for the execute stage.
// Iterative shift-add multiply and restoring radix-2 divide with a fixed
// 33-cycle latency. Divide-by-zero and signed overflow finish in one cycle.
// Build option: define MULDIV_FAST_MUL_EN to compute all four multiply ops
// in a single cycle with a combinational 33x33 signed multiplier.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      rd_id,
    input  logic            flush,
    output logic            busy,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      result_rd_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    // Operation context captured at accept
    logic [63:0] prod_r;          // mul: {acc, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] mcand_r;         // mul: |a| multiplicand; div: |b| divisor
    logic [5:0]  cnt_r;
    logic        res_neg_r;
    logic        mul_hi_r;
    logic        rem_sel_r;
    logic [4:0]  rd_lat_r;

    // Registered outputs
    logic        busy_r;
    logic        done_r;
    logic [31:0] result_r;
    logic [4:0]  result_rd_id_r;

    // Accept-time decode
    logic        signed_a_s;
    logic        signed_b_s;
    logic        neg_a_s;
    logic        neg_b_s;
    logic        res_neg_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic        div_zero_s;
    logic        div_ovf_s;
    logic        fast_mul_s;
    logic        fast_s;
    logic        accept_s;
    logic [31:0] fast_result_s;

    // Iteration datapath
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
    logic [32:0] div_shift_s;
    logic [63:0] div_next_s;
    logic [63:0] mul_signed_s;
    logic [31:0] div_raw_s;
    logic [31:0] iter_result_s;
    logic [63:0] step_next_s;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    // MULHSU treats only rs1 as signed; DIVU/REMU/MULHU are fully unsigned.
    assign signed_a_s = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    assign signed_b_s = op[2] ? ~op[0] : ~op[1];
    assign neg_a_s    = signed_a_s & operand_a[31];
    assign neg_b_s    = signed_b_s & operand_b[31];
    assign abs_a_s    = neg_a_s ? neg32(operand_a) : operand_a;
    assign abs_b_s    = neg_b_s ? neg32(operand_b) : operand_b;
    // Remainder takes the dividend's sign; everything else the product of signs.
    assign res_neg_s  = (op[2] & op[1]) ? neg_a_s : (neg_a_s ^ neg_b_s);

    assign div_zero_s = op[2] & (operand_b == 32'd0);
    assign div_ovf_s  = op[2] & ~op[0] & (operand_a == 32'h8000_0000) &
                        (operand_b == 32'hFFFF_FFFF);

`ifdef MULDIV_FAST_MUL_EN
    logic        ext_a_sign_s;
    logic        ext_b_sign_s;
    logic [63:0] ext_a_s;
    logic [63:0] ext_b_s;
    logic [63:0] fast_prod_s;

    // 33-bit operands (sign bit chosen per op) sign-extended; low 64 bits hold the exact product.
    assign ext_a_sign_s = signed_a_s & operand_a[31];
    assign ext_b_sign_s = signed_b_s & operand_b[31];
    assign ext_a_s      = {{31{ext_a_sign_s}}, ext_a_sign_s, operand_a};
    assign ext_b_s      = {{31{ext_b_sign_s}}, ext_b_sign_s, operand_b};
    assign fast_prod_s  = ext_a_s * ext_b_s;
    assign fast_mul_s   = ~op[2];
`else
    assign fast_mul_s   = 1'b0;
`endif

    assign fast_s   = div_zero_s | div_ovf_s | fast_mul_s;
    assign accept_s = start & (state_r == ST_IDLE) & ~flush;

    // Single-cycle results: divide special cases and, optionally, the fast multiplier
    always_comb begin
        fast_result_s = 32'd0;
        if (div_zero_s) begin
            fast_result_s = op[1] ? operand_a : 32'hFFFF_FFFF;
        end else if (div_ovf_s) begin
            fast_result_s = op[1] ? 32'd0 : 32'h8000_0000;
        end else begin
`ifdef MULDIV_FAST_MUL_EN
            fast_result_s = (op[1:0] == 2'b00) ? fast_prod_s[31:0] : fast_prod_s[63:32];
`else
            fast_result_s = 32'd0;
`endif
        end
    end

    // One shift-add multiply step and one restoring divide step on the shared register
    always_comb begin
        mul_sum_s   = {1'b0, prod_r[63:32]} + (prod_r[0] ? {1'b0, mcand_r} : 33'd0);
        mul_next_s  = {mul_sum_s, prod_r[31:1]};
        div_shift_s = {prod_r[63:32], prod_r[31]};
        div_next_s  = {div_shift_s[31:0], prod_r[30:0], 1'b0};
        if (div_shift_s >= {1'b0, mcand_r}) begin
            div_next_s = {div_shift_s[31:0] - mcand_r, prod_r[30:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[31:0], prod_r[30:0], 1'b0};
        end
    end

    // Final result selection with the single sign correction applied at load
    always_comb begin
        mul_signed_s  = res_neg_r ? neg64(mul_next_s) : mul_next_s;
        div_raw_s     = rem_sel_r ? div_next_s[63:32] : div_next_s[31:0];
        iter_result_s = 32'd0;
        step_next_s   = div_next_s;
        if (state_r == ST_MUL) begin
            iter_result_s = mul_hi_r ? mul_signed_s[63:32] : mul_signed_s[31:0];
            step_next_s   = mul_next_s;
        end else begin
            iter_result_s = res_neg_r ? neg32(div_raw_s) : div_raw_s;
            step_next_s   = div_next_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; flush overrides everything, including a same-cycle start
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (fast_s) begin
                            state_nxt_s = ST_DONE;
                        end else if (op[2]) begin
                            state_nxt_s = ST_DIV;
                        end else begin
                            state_nxt_s = ST_MUL;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cnt_r == 6'd31) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_DONE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: hold the pipeline from the accept cycle until the result is loaded
    always_comb begin
        case (state_r)
            ST_IDLE:        stall_req = start;
            ST_MUL, ST_DIV: stall_req = 1'b1;
            ST_DONE:        stall_req = 1'b0;
            default:        stall_req = 1'b0;
        endcase
    end

    // Operand capture, iteration and registered result/status
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_r         <= 64'd0;
            mcand_r        <= 32'd0;
            cnt_r          <= 6'd0;
            res_neg_r      <= 1'b0;
            mul_hi_r       <= 1'b0;
            rem_sel_r      <= 1'b0;
            rd_lat_r       <= 5'd0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            result_r       <= 32'd0;
            result_rd_id_r <= 5'd0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= 1'b0;
            if (accept_s) begin
                rd_lat_r  <= rd_id;
                cnt_r     <= 6'd0;
                res_neg_r <= res_neg_s;
                mul_hi_r  <= (op[1:0] != 2'b00);
                rem_sel_r <= op[1];
                if (op[2]) begin
                    prod_r  <= {32'd0, abs_a_s};
                    mcand_r <= abs_b_s;
                end else begin
                    prod_r  <= {32'd0, abs_b_s};
                    mcand_r <= abs_a_s;
                end
                if (fast_s) begin
                    result_r       <= fast_result_s;
                    result_rd_id_r <= rd_id;
                    done_r         <= 1'b1;
                end
            end else if (((state_r == ST_MUL) || (state_r == ST_DIV)) && !flush) begin
                prod_r <= step_next_s;
                cnt_r  <= cnt_r + 6'd1;
                if (cnt_r == 6'd31) begin
                    result_r       <= iter_result_s;
                    result_rd_id_r <= rd_lat_r;
                    done_r         <= 1'b1;
                end
            end
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign result       = result_r;
    assign result_rd_id = result_rd_id_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected results are queued at issue
// from an arithmetic reference model; a monitor pops and compares on done.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_id;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] result;
    logic [4:0]  result_rd_id;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .rd_id        (rd_id),
        .flush        (flush),
        .busy         (busy),
        .stall_req    (stall_req),
        .done         (done),
        .result       (result),
        .result_rd_id (result_rd_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endfunction

    // RV32M semantics with plain integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          ia, ib;
        logic [31:0] r;
        ia = a; ib = b; sa = ia; sb = ib; ub = {32'd0, b};
        r = 32'd0;
        case (o)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = ia / ib;
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = ia % ib;
            end
            3'd7: r = (b == 32'd0) ? a : a % b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bit fast;
        fast = (o[2] && b == 32'd0) ||
               ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef MULDIV_FAST_MUL_EN
        if (!o[2]) fast = 1'b1;
`endif
        return fast ? 1 : 33;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: result %h rd %0d, expected no done", result, result_rd_id);
            end else begin
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("result_rd_id", {27'd0, result_rd_id}, {27'd0, e.rd});
            end
        end
    end

    // Issue one op in the current (IDLE) cycle and track latency and stall/busy profile.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input bit noise);
        int lat;
        int got;
        bit prof_ok;
        lat = exp_lat(o, a, b);
        got = -1;
        prof_ok = 1'b1;
        start = 1'b1; op = o; operand_a = a; operand_b = b; rd_id = r;
        exp_q.push_back('{res: ref_model(o, a, b), rd: r});
        @(negedge clk);
        if (stall_req !== 1'b1 || busy !== 1'b0) prof_ok = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                op = 3'($urandom);
                operand_a = $urandom;
                operand_b = $urandom;
                rd_id = 5'($urandom);
            end
            @(negedge clk);
            if (busy !== 1'b1) prof_ok = 1'b0;
            if (stall_req !== (n < lat)) prof_ok = 1'b0;
            if (done === 1'b1) begin
                got = n;
                start = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(posedge clk); #1;
        if (busy !== 1'b0) prof_ok = 1'b0;
        chk("latency", got, lat);
        chk("stall_busy_profile", {31'd0, prof_ok}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        op = 3'd0; operand_a = 32'd0; operand_b = 32'd0; rd_id = 5'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_rd", {27'd0, result_rd_id}, 32'd0);
        chk("reset_stall", {31'd0, stall_req}, 32'd0);

        // flush beats start in the same cycle: stall follows start but nothing is accepted
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = 3'd4; operand_a = 32'd9; operand_b = 32'd2;
        @(negedge clk);
        chk("stall_follows_start", {31'd0, stall_req}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_blocks_accept", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // directed cases
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b0);
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 5'd2, 1'b0);
        run_op(3'd4, 32'd7, 32'hFFFF_FFFE, 5'd3, 1'b0);
        run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd4, 1'b0);
        run_op(3'd5, 32'd5, 32'd0, 5'd5, 1'b0);
        run_op(3'd7, 32'd5, 32'd0, 5'd6, 1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b0);

        // flush an in-flight DIVU at cycle 10, then start MULHU in cycle 11
        start = 1'b1; op = 3'd5; operand_a = 32'd123456; operand_b = 32'd77; rd_id = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        chk("busy_before_flush", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("busy_after_flush", {31'd0, busy}, 32'd0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b0);

        // reset at cycle 20 of a DIV, then DIV 100/7
        start = 1'b1; op = 3'd4; operand_a = 32'd1000; operand_b = 32'd3; rd_id = 5'd11;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_result", result, 32'd0);
        chk("midreset_rd", {27'd0, result_rd_id}, 32'd0);
        chk("midreset_stall", {31'd0, stall_req}, 32'd0);
        run_op(3'd4, 32'd100, 32'd7, 5'd19, 1'b0);

        // randomized ops with junk on the inputs while busy
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 20); end
                3: rb = ~rb + 32'd1 - 32'($urandom_range(0, 3));
                default: ;
            endcase
            run_op(ro, ra, rb, 5'($urandom), 1'b1);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Multi-cycle RV32M multiply/divide unit in the execute stage. Consumes the post-forwarding operands (the values selected by the rs1/rs2 forwarding muxes) for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. Holds the pipeline via a stall request until the registered result is ready. Returns the result together with its destination register id for the EX/MEM register.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  ID/EX holds a valid M-extension instruction; sampled only in IDLE.
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  input  32  forwarded rs1 value, sampled at accept.
- operand_b  input  32  forwarded rs2 value, sampled at accept.
- rd_id  input  5  destination register, sampled at accept.
- flush  input  1  kill the in-flight operation (branch mispredict/exception).
- busy  output  1  high in MUL, DIV and DONE states.
- stall_req  output  1  combinational: (start & state==IDLE) | (state==MUL) | (state==DIV); low in the DONE cycle.
- done  output  1  one-cycle pulse; result and result_rd_id are valid.
- result  output  32  registered result.
- result_rd_id  output  5  registered destination id.

## Operation
- States: IDLE, MUL, DIV, DONE.
  - IDLE→DONE on a fast path.
  - IDLE→MUL or IDLE→DIV on accept.
  - MUL/DIV→DONE when the iteration counter reaches 31.
  - DONE→IDLE always.
- Accept = start & state==IDLE & !flush. Operands, op and rd_id are latched. start in any other state is ignored.
- Signed handling: latch |a| and |b| per op signedness; MULHSU treats only a as signed. Record the result sign, apply two's-complement negation once when loading result.
- Multiply: unsigned shift-add, one bit of b per cycle, into a 64-bit product register.
  - MUL returns product[31:0].
  - MULH/MULHSU/MULHU return the corrected product[63:32].
- Divide: restoring radix-2, one quotient bit per cycle; 6-bit counter 0..31.
  - Quotient sign = sign(a) xor sign(b).
  - Remainder sign = sign(a).
- Fast paths: no iteration; enter DONE directly from IDLE.
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → operand_a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- flush in any state: next state IDLE, done never pulses for the killed op. flush has priority over start in the same cycle.
- Reset values: state IDLE; busy, done, result and result_rd_id all 0. stall_req follows start in IDLE.

## Timing
- Accept in cycle 0.
- Iterative op: busy high cycles 1..33; done pulses in cycle 33; stall_req high in cycles 0..32. Latency is 33 cycles, independent of operand values (no early-out).
- Fast path: done in cycle 1; stall_req high in cycle 0 only.
- Back-to-back: a new start is accepted no earlier than the cycle after done (the IDLE cycle).
- reset mid-operation: IDLE in the next cycle, no done pulse.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - All four multiply ops are single-cycle, computed by a combinational 33x33 signed multiplier at accept.
  - Path is IDLE→DONE; done in cycle 1.
  - MUL state is unused.
- MULDIV_FAST_MUL_EN undefined: multiplies use the 32-iteration shift-add path with the same 33-cycle latency as divide.
- Divide behaviour is identical in both builds.

## Test plan
- MULH/MUL: a=0x80000000, b=0x80000000. MULH → 0x40000000; MUL → 0x00000000. done at cycle 33, or cycle 1 with MULDIV_FAST_MUL_EN.
- DIV a=7, b=0xFFFFFFFE (−2) → 0xFFFFFFFD. REM with the same operands → 0x00000001. done exactly at cycle 33; stall_req high cycles 0..32.
- DIVU a=5, b=0 → 0xFFFFFFFF. REMU a=5, b=0 → 0x00000005. Both done at cycle 1.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000. REM with the same operands → 0. Both done at cycle 1.
- DIVU started, flush at cycle 10: busy low at cycle 11, no done pulse. New MULHU 0xFFFFFFFF×0xFFFFFFFF accepted at cycle 11 → 0xFFFFFFFE.
- reset asserted at cycle 20 of a DIV: all outputs 0 next cycle, no done pulse. A start of DIV 100/7 afterwards → 14, with result_rd_id equal to the new rd_id.
